// File: rtl/mod_reduce_256.sv
// Reduces a DW-bit dividend modulo an MW-bit modulus by restoring shift-subtract,
// one dividend bit per clock, with valid/ready handshakes on both sides.
module mod_reduce_256 #(
  parameter int DW = 256,
  parameter int MW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [MW-1:0] modulus,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] remainder,
  output logic          div_zero
);
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] d;
  logic [MW-1:0] m;
  logic [MW-1:0] r;
  logic [MW:0]   t;
  logic [MW-1:0] r_nxt;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = (state == IDLE) && in_valid;

  // r < m always holds, so only the shifted-in trial value needs the extra bit;
  // the difference after a successful subtract again fits in MW bits.
  always_comb begin
    t     = {r, d[DW-1]};
    r_nxt = t[MW-1:0];
    if (t >= {1'b0, m}) r_nxt = MW'(t - {1'b0, m});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = (modulus == '0) ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d         <= '0;
      m         <= '0;
      r         <= '0;
      cnt       <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      d        <= dividend;
      m        <= modulus;
      r        <= '0;
      cnt      <= CW'(DW - 1);
      div_zero <= (modulus == '0);
      if (modulus == '0) remainder <= '0;
    end else if (state == CALC) begin
      d   <= d << 1;
      r   <= r_nxt;
      cnt <= cnt - CW'(1);
      if (cnt == '0) remainder <= r_nxt;
    end
  end

  a_rem_lt_mod: assert property (@(posedge clk) disable iff (!reset)
    (out_valid && !div_zero) |-> (remainder < m));

endmodule

// File: tb/tb_mod_reduce_256.sv
// Directed bench for mod_reduce_256: hand-computed remainders, latency,
// backpressure, mid-calculation reset and back-to-back requests.
module tb_mod_reduce_256;
  localparam int DW = 256;
  localparam int MW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [MW-1:0] modulus = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [MW-1:0] remainder;
  logic          div_zero;

  int pass_cnt = 0;
  int total    = 0;

  mod_reduce_256 #(.DW(DW), .MW(MW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .modulus(modulus),
    .out_valid(out_valid), .out_ready(out_ready),
    .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Issue one request and count edges after the accepting edge until out_valid
  // (0 = visible right after the accepting edge, -1 = never accepted / timed out).
  task automatic run_req(input logic [DW-1:0] dv, input logic [MW-1:0] mv, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    lat = -1;
    if (!in_ready) return;
    dividend = dv; modulus = mv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || remainder !== '0 || div_zero !== 1'b0)
      $display("FAIL reset_state: in_ready=%b out_valid=%b remainder=%0d div_zero=%b, want 1 0 0 0",
               in_ready, out_valid, remainder, div_zero);
    else pass_cnt++;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    dividend = 256'd100; modulus = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) $display("FAIL basic_busy: in_ready=%b want 0", in_ready);
    else pass_cnt++;
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1; lat++;
    end
    total++;
    if (lat !== 256) $display("FAIL basic_latency: got %0d edges want 256", lat);
    else pass_cnt++;
    total++;
    if (remainder !== 64'd2 || div_zero !== 1'b0)
      $display("FAIL basic_100mod7: remainder=%0d div_zero=%b want 2 0", remainder, div_zero);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_wide();
    int lat;
    logic [DW-1:0] dv;
    dv = '0; dv[64] = 1'b1;
    run_req(dv, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    total++;
    if (lat !== 256 || remainder !== 64'd1)
      $display("FAIL wide_2pow64: lat=%0d remainder=%0h want 256 1", lat, remainder);
    else pass_cnt++;
    consume();
    dv = '1;
    run_req(dv, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    total++;
    if (lat !== 256 || remainder !== 64'd0)
      $display("FAIL wide_allones: lat=%0d remainder=%0h want 256 0", lat, remainder);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_boundaries();
    int lat;
    logic [DW-1:0] dv;
    run_req(256'd5, 64'd9, lat);
    total++;
    if (lat !== 256 || remainder !== 64'd5 || div_zero !== 1'b0)
      $display("FAIL small_5mod9: lat=%0d remainder=%0d div_zero=%b want 256 5 0", lat, remainder, div_zero);
    else pass_cnt++;
    consume();
    dv = '0; dv[200] = 1'b1; dv[3:0] = 4'hB;
    run_req(dv, 64'd1, lat);
    total++;
    if (lat !== 256 || remainder !== 64'd0 || div_zero !== 1'b0)
      $display("FAIL mod_one: lat=%0d remainder=%0d div_zero=%b want 256 0 0", lat, remainder, div_zero);
    else pass_cnt++;
    consume();
    run_req(256'd0, 64'd12345, lat);
    total++;
    if (lat !== 256 || remainder !== 64'd0)
      $display("FAIL zero_dividend: lat=%0d remainder=%0d want 256 0", lat, remainder);
    else pass_cnt++;
    consume();
    // Leave a nonzero remainder behind so the div-zero clear is observable.
    run_req(256'd100, 64'd7, lat);
    consume();
    dv = '1;
    run_req(dv, 64'd0, lat);
    total++;
    if (lat !== 0 || remainder !== 64'd0 || div_zero !== 1'b1)
      $display("FAIL div_zero: lat=%0d remainder=%0d div_zero=%b want 0 0 1", lat, remainder, div_zero);
    else pass_cnt++;
    consume();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL div_zero_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    run_req(256'd1000, 64'd13, lat);
    total++;
    if (lat !== 256 || remainder !== 64'd12)
      $display("FAIL bp_result: lat=%0d remainder=%0d want 256 12", lat, remainder);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      dividend = 256'(i * 77 + 3);
      modulus  = 64'(i + 2);
      @(posedge clk); #1;
      if (remainder !== 64'd12 || div_zero !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    total++;
    if (bad !== 0)
      $display("FAIL bp_hold: %0d cycles changed, remainder=%0d in_ready=%b out_valid=%b want 12 0 1",
               bad, remainder, in_ready, out_valid);
    else pass_cnt++;
    consume();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat;
    dividend = 256'd100; modulus = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_mid: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    else pass_cnt++;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_no_partial: out_valid=%b want 0", out_valid);
    else pass_cnt++;
    run_req(256'd15, 64'd4, lat);
    total++;
    if (lat !== 256 || remainder !== 64'd3)
      $display("FAIL reset_then_15mod4: lat=%0d remainder=%0d want 256 3", lat, remainder);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    dividend = 256'd100; modulus = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    dividend = 256'd1000; modulus = 64'd13;  // second request held pending
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1; lat++;
    end
    total++;
    if (lat !== 256 || remainder !== 64'd2 || in_ready !== 1'b0)
      $display("FAIL b2b_first: lat=%0d remainder=%0d in_ready=%b want 256 2 0", lat, remainder, in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_idle: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0)
      $display("FAIL b2b_accept2: in_ready=%b want 0", in_ready);
    else pass_cnt++;
    lat = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk); #1; lat++;
    end
    total++;
    if (lat !== 256 || remainder !== 64'd12)
      $display("FAIL b2b_second: lat=%0d remainder=%0d want 256 12", lat, remainder);
    else pass_cnt++;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_boundaries();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
